// File: rtl/nf_mdu_pkg.sv
// nf_mdu_pkg: operation codes, flag bit positions and shared helpers for the
// iterative multiply/divide unit (nf_mdu) and its iteration step (nf_mdu_step).
package nf_mdu_pkg;

    // RV32M operation codes carried on req_op.
    localparam logic [2:0] MDU_MUL    = 3'd0;
    localparam logic [2:0] MDU_MULH   = 3'd1;
    localparam logic [2:0] MDU_MULHSU = 3'd2;
    localparam logic [2:0] MDU_MULHU  = 3'd3;
    localparam logic [2:0] MDU_DIV    = 3'd4;
    localparam logic [2:0] MDU_DIVU   = 3'd5;
    localparam logic [2:0] MDU_REM    = 3'd6;
    localparam logic [2:0] MDU_REMU   = 3'd7;

    // Bit positions inside mdu_flags.
    localparam int MDU_FLAG_ZERO = 0;
    localparam int MDU_FLAG_DIVZ = 1;
    localparam int MDU_FLAG_OVF  = 2;

    // Iteration kind performed by nf_mdu_step.
    typedef enum logic {
        STEP_MUL = 1'b0,
        STEP_DIV = 1'b1
    } step_mode_e;

    // All divide/remainder codes have the top bit set.
    function automatic logic op_is_div(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/nf_mdu_step.sv
// nf_mdu_step: one combinational radix-2 iteration of the multiply/divide unit.
//   mode_i  STEP_MUL: shift-add,  acc = {partial product high, multiplier bits}
//           STEP_DIV: restoring shift-subtract, acc = {remainder, quotient/dividend}
//   acc_i   2*XLEN working register in
//   opb_i   multiplicand (multiply) or divisor (divide) magnitude
//   acc_o   2*XLEN working register after one iteration
module nf_mdu_step
    import nf_mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  step_mode_e        mode_i,
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [XLEN-1:0]   opb_i,
    output logic [2*XLEN-1:0] acc_o
);

    logic [XLEN:0] sum;   // high half + multiplicand, carry kept
    logic [XLEN:0] rem_sh;  // remainder shifted left with next dividend bit
    logic [XLEN:0] diff;  // trial subtraction

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sum    = {1'b0, acc_i[2*XLEN-1:XLEN]} + {1'b0, opb_i};
        rem_sh = acc_i[2*XLEN-1:XLEN-1];
        diff   = rem_sh - {1'b0, opb_i};
        acc_o  = '0;
        if (mode_i == STEP_MUL) begin
            // Consume the multiplier LSB, then shift the whole register right.
            if (acc_i[0]) acc_o = {sum, acc_i[XLEN-1:1]};
            else          acc_o = {1'b0, acc_i[2*XLEN-1:1]};
        end else begin
            // Borrow in diff[XLEN] means the divisor did not fit: restore.
            if (!diff[XLEN]) acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
            else             acc_o = {acc_i[2*XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/nf_mdu.sv
// nf_mdu: iterative RV32M multiply/divide unit, one result bit per cycle.
//   clk, resetn            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready    operation request handshake (ready only in IDLE)
//   req_op, srcA, srcB     operation code and operands, sampled on accept only
//   flush                  synchronous kill of the in-flight operation
//   res_valid/res_ready    result handshake
//   result, mdu_flags      result and {overflow, divide-by-zero, zero} flags
// Divide by zero and signed overflow complete in one cycle; all other
// operations take XLEN iterations plus the accept cycle.
module nf_mdu
    import nf_mdu_pkg::*;
#(
    parameter  int XLEN = 32,
    localparam int CW   = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] srcA,
    input  logic [XLEN-1:0] srcB,
    input  logic            flush,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [XLEN-1:0] result,
    output logic [2:0]      mdu_flags
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;      // final result needs negation
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [2:0]        flags_q, flags_d;

    // Accept-side operand decode.
    logic              accept, sgn_a, sgn_b, fast_divz, fast_ovf;
    logic [XLEN-1:0]   mag_a, mag_b, fast_res;

    always_comb begin
        accept = req_valid && (state_q == S_IDLE) && !flush;
        sgn_a  = srcA[XLEN-1] && (req_op == MDU_MULH || req_op == MDU_MULHSU ||
                                  req_op == MDU_DIV  || req_op == MDU_REM);
        sgn_b  = srcB[XLEN-1] && (req_op == MDU_MULH || req_op == MDU_DIV ||
                                  req_op == MDU_REM);
        mag_a  = sgn_a ? -srcA : srcA;
        mag_b  = sgn_b ? -srcB : srcB;
        fast_divz = op_is_div(req_op) && (srcB == '0);
        fast_ovf  = (req_op == MDU_DIV || req_op == MDU_REM) &&
                    (srcA == MIN_NEG) && (srcB == '1);
        fast_res  = '0;
        if (fast_divz)
            fast_res = (req_op == MDU_DIV || req_op == MDU_DIVU) ? '1 : srcA;
        else if (fast_ovf)
            fast_res = (req_op == MDU_DIV) ? srcA : '0;
    end

    // Single iteration; a radix-4 variant would chain a second instance.
    step_mode_e        step_mode;
    logic [2*XLEN-1:0] step_acc;

    assign step_mode = op_is_div(op_q) ? STEP_DIV : STEP_MUL;

    nf_mdu_step #(.XLEN(XLEN)) u_step (
        .mode_i (step_mode),
        .acc_i  (acc_q),
        .opb_i  (opb_q),
        .acc_o  (step_acc)
    );

    // Sign correction and result selection on the final iteration.
    logic [2*XLEN-1:0] prod_full;
    logic [XLEN-1:0]   div_sel, fin_res;

    always_comb begin
        prod_full = neg_q ? -step_acc : step_acc;
        div_sel   = (op_q == MDU_DIV || op_q == MDU_DIVU) ? step_acc[XLEN-1:0]
                                                          : step_acc[2*XLEN-1:XLEN];
        case (op_q)
            MDU_MUL:                         fin_res = prod_full[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: fin_res = prod_full[2*XLEN-1:XLEN];
            default:                         fin_res = neg_q ? -div_sel : div_sel;
        endcase
    end

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        result_d = result_q;
        flags_d  = flags_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d  = req_op;
                    // Remainder follows the dividend; everything else sign(A)^sign(B).
                    neg_d = (req_op == MDU_REM) ? sgn_a : (sgn_a ^ sgn_b);
                    if (op_is_div(req_op)) begin
                        acc_d = {{XLEN{1'b0}}, mag_a};
                        opb_d = mag_b;
                    end else begin
                        acc_d = {{XLEN{1'b0}}, mag_b};
                        opb_d = mag_a;
                    end
                    if (fast_divz || fast_ovf) begin
                        result_d = fast_res;
                        flags_d  = '0;
                        flags_d[MDU_FLAG_ZERO] = (fast_res == '0);
                        flags_d[MDU_FLAG_DIVZ] = fast_divz;
                        flags_d[MDU_FLAG_OVF]  = fast_ovf && !fast_divz;
                        state_d  = S_DONE;
                    end else begin
                        cnt_d   = CNT_LAST;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = step_acc;
                    if (cnt_q == '0) begin
                        result_d = fin_res;
                        flags_d  = '0;
                        flags_d[MDU_FLAG_ZERO] = (fin_res == '0);
                        state_d  = S_DONE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            S_DONE: begin
                if (flush || res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign res_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign mdu_flags = flags_q;

endmodule

// File: tb/tb_nf_mdu.sv
// tb_nf_mdu: self-checking bench for nf_mdu (XLEN=32). Directed vectors,
// randomized operations against a 64-bit arithmetic reference model,
// backpressure, flush, back-to-back handshake and mid-operation reset.
module tb_nf_mdu;
    import nf_mdu_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = '0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        flush = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] result;
    logic [2:0]  mdu_flags;

    int vectors = 0;
    int miscompares = 0;

    nf_mdu #(.XLEN(32)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .srcA      (src_a),
        .srcB      (src_b),
        .flush     (flush),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .result    (result),
        .mdu_flags (mdu_flags)
    );

    always #5 clk = ~clk;

    // Reference model: RV32M semantics via 64-bit integer arithmetic.
    function automatic void ref_model(input logic [2:0] op, input logic [31:0] a, b,
                                      output logic [31:0] res, output logic [2:0] flg,
                                      output int lat);
        longint unsigned ua, ub;
        longint          la, lb;
        int              ia, ib;
        logic [63:0]     p;
        ua = {32'd0, a};
        ub = {32'd0, b};
        ia = $signed(a);
        ib = $signed(b);
        la = ia;
        lb = ib;
        flg = '0;
        lat = 33;
        res = '0;
        case (op)
            MDU_MUL:    begin p = ua * ub; res = p[31:0]; end
            MDU_MULH:   begin p = la * lb; res = p[63:32]; end
            MDU_MULHSU: begin p = la * longint'(ub); res = p[63:32]; end
            MDU_MULHU:  begin p = ua * ub; res = p[63:32]; end
            default: begin
                if (b == 32'd0) begin
                    lat = 1;
                    flg[1] = 1'b1;
                    res = (op == MDU_DIV || op == MDU_DIVU) ? 32'hFFFF_FFFF : a;
                end else if ((op == MDU_DIV || op == MDU_REM) &&
                             a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lat = 1;
                    flg[2] = 1'b1;
                    res = (op == MDU_DIV) ? a : 32'd0;
                end else begin
                    case (op)
                        MDU_DIV:  res = ia / ib;
                        MDU_DIVU: res = a / b;
                        MDU_REM:  res = ia % ib;
                        default:  res = a % b;
                    endcase
                end
            end
        endcase
        flg[0] = (res == 32'd0);
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            4:       return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    // Present one request for one cycle; caller guarantees req_ready.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, b);
        req_op = op;
        src_a = a;
        src_b = b;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_op = 3'($urandom);
        src_a = $urandom;
        src_b = $urandom;
    endtask

    // Cycles from accept edge (counted as 1) until res_valid is seen.
    task automatic wait_result(output int lat);
        lat = 1;
        while (res_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic take_result();
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #12;
        vectors++;
        if (req_ready !== 1'b1 || res_valid !== 1'b0 || result !== 32'd0 || mdu_flags !== 3'd0) begin
            miscompares++;
            $display("FAIL reset: got ready=%b valid=%b result=%h flags=%b, want 1 0 00000000 000",
                     req_ready, res_valid, result, mdu_flags);
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, res;
        logic [2:0]  flg;
        int          lat;
    } vec_t;

    task automatic test_directed();
        vec_t tbl[15];
        int   lat;
        tbl = '{
            '{MDU_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 3'b000, 33},
            '{MDU_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 3'b000, 33},
            '{MDU_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 3'b001, 33},
            '{MDU_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b000, 33},
            '{MDU_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 3'b000, 33},
            '{MDU_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 3'b000, 33},
            '{MDU_DIVU,   32'd100,        32'd7,         32'd14,        3'b000, 33},
            '{MDU_REMU,   32'd100,        32'd7,         32'd2,         3'b000, 33},
            '{MDU_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 3'b010, 1},
            '{MDU_REM,    32'd5,          32'd0,         32'd5,         3'b010, 1},
            '{MDU_DIVU,   32'd9,          32'd0,         32'hFFFF_FFFF, 3'b010, 1},
            '{MDU_REMU,   32'd0,          32'd0,         32'd0,         3'b011, 1},
            '{MDU_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 3'b100, 1},
            '{MDU_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         3'b101, 1},
            '{MDU_DIVU,   32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         3'b001, 33}
        };
        foreach (tbl[i]) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].b);
            wait_result(lat);
            vectors++;
            if (result !== tbl[i].res) begin
                miscompares++;
                $display("FAIL directed[%0d] result: got %h, want %h", i, result, tbl[i].res);
            end
            vectors++;
            if (mdu_flags !== tbl[i].flg) begin
                miscompares++;
                $display("FAIL directed[%0d] flags: got %b, want %b", i, mdu_flags, tbl[i].flg);
            end
            vectors++;
            if (lat !== tbl[i].lat) begin
                miscompares++;
                $display("FAIL directed[%0d] latency: got %0d, want %0d", i, lat, tbl[i].lat);
            end
            take_result();
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b, exp_res;
        logic [2:0]  exp_flg;
        int          exp_lat, lat, hold;
        for (int n = 0; n < 150; n++) begin
            op = 3'($urandom_range(0, 7));
            a = pick_operand();
            b = pick_operand();
            ref_model(op, a, b, exp_res, exp_flg, exp_lat);
            issue(op, a, b);
            wait_result(lat);
            hold = $urandom_range(0, 2);
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
            end
            vectors++;
            if (result !== exp_res || mdu_flags !== exp_flg || lat !== exp_lat) begin
                miscompares++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h/%b/%0d, want %h/%b/%0d",
                         n, op, a, b, result, mdu_flags, lat, exp_res, exp_flg, exp_lat);
            end
            take_result();
            vectors++;
            if (req_ready !== 1'b1 || res_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL random[%0d] return to idle: got ready=%b valid=%b, want 1 0",
                         n, req_ready, res_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b, exp_res;
        logic [2:0]  exp_flg;
        int          exp_lat, lat;
        a = $urandom;
        b = 32'($urandom_range(1, 1000));
        ref_model(MDU_DIVU, a, b, exp_res, exp_flg, exp_lat);
        issue(MDU_DIVU, a, b);
        wait_result(lat);
        for (int c = 0; c < 5; c++) begin
            vectors++;
            if (result !== exp_res || mdu_flags !== exp_flg || req_ready !== 1'b0 || res_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL backpressure hold[%0d]: got %h/%b ready=%b valid=%b, want %h/%b 0 1",
                         c, result, mdu_flags, req_ready, res_valid, exp_res, exp_flg);
            end
            @(posedge clk); #1;
        end
        // Flush while the result is waiting: dropped, register keeps its value.
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        vectors++;
        if (res_valid !== 1'b0 || req_ready !== 1'b1 || result !== exp_res) begin
            miscompares++;
            $display("FAIL flush in done: got valid=%b ready=%b result=%h, want 0 1 %h",
                     res_valid, req_ready, result, exp_res);
        end
    endtask

    task automatic test_flush();
        logic [31:0] held;
        logic        rose;
        held = result;
        issue(MDU_DIVU, $urandom, 32'($urandom_range(1, 50)));
        for (int c = 1; c < 10; c++) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        vectors++;
        if (req_ready !== 1'b1 || res_valid !== 1'b0 || result !== held) begin
            miscompares++;
            $display("FAIL flush in calc: got ready=%b valid=%b result=%h, want 1 0 %h",
                     req_ready, res_valid, result, held);
        end
        rose = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (res_valid !== 1'b0) rose = 1'b1;
        end
        vectors++;
        if (rose !== 1'b0) begin
            miscompares++;
            $display("FAIL flush drop: res_valid rose=%b after flush, want 0", rose);
        end
        // Flush beats a request presented in IDLE.
        req_valid = 1'b1;
        req_op = MDU_MUL;
        flush = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        flush = 1'b0;
        vectors++;
        if (req_ready !== 1'b1 || res_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush in idle: got ready=%b valid=%b, want 1 0", req_ready, res_valid);
        end
        repeat (40) @(posedge clk);
        #1;
        vectors++;
        if (res_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush in idle accept: got valid=%b, want 0", res_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_res;
        logic [2:0]  exp_flg;
        int          exp_lat, lat;
        issue(MDU_REMU, 32'd1000, 32'd33);
        wait_result(lat);
        // Handshake with a new request already pending: it must not be taken yet.
        res_ready = 1'b1;
        req_valid = 1'b1;
        req_op = MDU_MULHU;
        src_a = 32'h1234_5678;
        src_b = 32'h9ABC_DEF0;
        @(posedge clk); #1;
        res_ready = 1'b0;
        vectors++;
        if (req_ready !== 1'b1 || res_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b no same-cycle accept: got ready=%b valid=%b, want 1 0",
                     req_ready, res_valid);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        vectors++;
        if (req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b accept: got ready=%b, want 0", req_ready);
        end
        ref_model(MDU_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, exp_res, exp_flg, exp_lat);
        wait_result(lat);
        vectors++;
        if (result !== exp_res || mdu_flags !== exp_flg || lat !== exp_lat) begin
            miscompares++;
            $display("FAIL b2b result: got %h/%b/%0d, want %h/%b/%0d",
                     result, mdu_flags, lat, exp_res, exp_flg, exp_lat);
        end
        take_result();
    endtask

    task automatic test_reset_mid_op();
        int lat;
        issue(MDU_MUL, $urandom, $urandom);
        for (int c = 1; c < 20; c++) begin
            @(posedge clk); #1;
        end
        #2;
        resetn = 1'b0;
        #1;
        vectors++;
        if (req_ready !== 1'b1 || res_valid !== 1'b0 || result !== 32'd0 || mdu_flags !== 3'd0) begin
            miscompares++;
            $display("FAIL reset mid-op: got ready=%b valid=%b result=%h flags=%b, want 1 0 00000000 000",
                     req_ready, res_valid, result, mdu_flags);
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        issue(MDU_MUL, 32'd3, 32'd4);
        wait_result(lat);
        vectors++;
        if (result !== 32'd12 || mdu_flags !== 3'd0 || lat !== 33) begin
            miscompares++;
            $display("FAIL mul after reset: got %h/%b/%0d, want 0000000c/000/33",
                     result, mdu_flags, lat);
        end
        take_result();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_flush();
        test_back_to_back();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/nf_mdu.md
Name: nf_mdu

Overview:
- Parametrised iterative multiply/divide unit implementing the RV32M operation set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Successor to the single-cycle combinational ALU, covering the long operations that do not fit in one cycle.
- Sits beside the ALU in the execute stage. The pipeline issues one operation over a valid/ready handshake and stalls until the result handshake completes.
- Computes 1 bit per cycle, with fast paths for divide-by-zero and signed overflow.

Parameters:
- XLEN, 32, operand/result width; legal values are 8 and above, powers of two.
- CW, $clog2(XLEN)+1, iteration counter width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- req_valid  in  1  operation request
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_op  in  3  operation code, MDU_* encodings from the shared header
- srcA  in  XLEN  operand A (multiplicand / dividend)
- srcB  in  XLEN  operand B (multiplier / divisor)
- flush  in  1  synchronous kill of the in-flight operation
- res_valid  out  1  result available
- res_ready  in  1  consumer takes result
- result  out  XLEN  operation result
- mdu_flags  out  3  [0] result==0, [1] divide by zero, [2] signed overflow (DIV/REM of -2^(XLEN-1) by -1)

Behaviour:
- Reset (async, resetn=0): state IDLE, req_ready=1, res_valid=0, result=0, mdu_flags=0, counter=0, all datapath registers 0.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - On req_valid&&req_ready, latch op, operand signs and operand magnitudes.
  - MULH/DIV/REM take the magnitude of both operands. MULHSU takes the magnitude of A only. Unsigned ops take operands as-is.
  - Next state is CALC, except for the fast cases below, which go straight to DONE.
- Fast cases (DIV/DIVU/REM/REMU only):
  - srcB==0: quotient = all ones, remainder = srcA, flag[1]=1.
  - Signed DIV/REM with srcA=1<<(XLEN-1) and srcB=all ones: quotient = srcA, remainder = 0, flag[2]=1.
  - res_valid rises the cycle after accept (latency 1).
- CALC:
  - Runs exactly XLEN cycles, counter XLEN-1 down to 0.
  - Multiply: shift-add into a 2*XLEN product register.
  - Divide: restoring shift-subtract producing XLEN-bit quotient and remainder.
  - When the counter reaches 0: apply sign correction, select the result, register result and flags, go to DONE.
  - Latency from accept edge to res_valid high is XLEN+1 cycles.
- Result selection:
  - MUL: low XLEN bits of the product.
  - MULH/MULHSU/MULHU: high XLEN bits of the product.
  - Product sign: negate if sign(A)^sign(B) for MULH; sign(A) for MULHSU.
  - Quotient negated if sign(A)^sign(B). Remainder takes the sign of the dividend.
- DONE:
  - res_valid=1. result and mdu_flags are held stable until res_ready=1.
  - On handshake, go to IDLE next cycle, with res_valid=0 and req_ready=1.
  - A new request is not accepted in the same cycle as the result handshake.
- flush=1 in CALC or DONE: next state IDLE, res_valid=0. The result register keeps its old value and the op is dropped. flush in IDLE has priority over req_valid, so no accept occurs.
- req_op, srcA and srcB are ignored outside the accept cycle.
- Reset mid-operation: immediate return to reset values; no partial result is ever presented.
- Undefined req_op values (none exist in 3 bits) are not applicable. All 8 codes are legal.

Decomposition:
- Shared header nf_cpu_commands.svh (existing) gains:
  - the MDU_MUL..MDU_REMU 3-bit codes: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7;
  - the flag bit index constants.
- FSM state enum lives in the module.
- One sub-module: nf_mdu_step, a combinational single iteration (shift-add or shift-subtract selected by a mode input). It is instantiated once, leaving room for a future radix-4 variant with two instances.

Test Plan:
- MUL srcA=7, srcB=0xFFFFFFFD -> result 0xFFFFFFEB, res_valid exactly 33 cycles after accept, flags 0.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000 with flag[0]=1; MULHSU srcA=0xFFFFFFFF, srcB=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF, flag[1]=1, latency 1; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, flag[2]=1; REM same -> 0.
- Backpressure: hold res_ready=0 for 5 cycles in DONE -> result/flags stable, req_ready=0; then flush at CALC cycle 10 of a new DIVU -> IDLE next cycle, res_valid never rises.
- resetn pulsed low in CALC cycle 20 -> all outputs at reset values immediately; next MUL 3*4 -> 12 with normal latency.
